// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS core: opcodes, functs,
// FSM state encoding and ALU operation encoding, plus the ALU itself.
package mips_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpOri   = 6'h0D;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluNor
    } alu_op_e;

    // Plain 32-bit wrap-around arithmetic; overflow is never trapped.
    function automatic logic [31:0] alu_compute(input logic [31:0] a, input logic [31:0] b,
                                                input alu_op_e op);
        logic [31:0] result;
        case (op)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluNor:  result = ~(a | b);
            default: result = a + b;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mips_core_if.sv
// External bus of the multicycle core: run control, port I/O, program-memory
// load channel and status outputs. master = environment, slave = core.
interface mips_core_if;
    logic        Stall;
    logic [7:0]  PortIn;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [31:0] ALUResultOut;
    logic [31:0] PortOut;
    logic [31:0] PCOut;
    logic        InstrRetired;
    logic        Halted;

    modport master (
        output Stall, PortIn, prog_we, prog_addr, prog_data,
        input  ALUResultOut, PortOut, PCOut, InstrRetired, Halted
    );

    modport slave (
        input  Stall, PortIn, prog_we, prog_addr, prog_data,
        output ALUResultOut, PortOut, PCOut, InstrRetired, Halted
    );
endinterface

// File: rtl/mips_mc_control.sv
// FETCH->DECODE->EXEC->WB controller with instruction decode; illegal
// encodings seen in DECODE park the core in a sticky HALT state.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_e     state,
    output alu_op_e    alu_op,
    output logic       use_imm,
    output logic       reg_write,
    output logic       write_rt,
    output logic       is_branch,
    output logic       branch_ne,
    output logic       retired,
    output logic       halted
);

    logic    legal;
    alu_op_e dec_op;
    logic    dec_imm, dec_write, dec_rt, dec_branch, dec_ne;

    always_comb begin
        legal      = 1'b1;
        dec_op     = AluAdd;
        dec_imm    = 1'b0;
        dec_write  = 1'b0;
        dec_rt     = 1'b0;
        dec_branch = 1'b0;
        dec_ne     = 1'b0;
        case (opcode)
            OpRtype: begin
                dec_write = 1'b1;
                case (funct)
                    FnAdd:   dec_op = AluAdd;
                    FnSub:   dec_op = AluSub;
                    FnAnd:   dec_op = AluAnd;
                    FnOr:    dec_op = AluOr;
                    FnNor:   dec_op = AluNor;
                    default: legal = 1'b0;
                endcase
            end
            OpAddi: begin
                dec_imm   = 1'b1;
                dec_write = 1'b1;
                dec_rt    = 1'b1;
            end
            OpOri: begin
                dec_op    = AluOr;
                dec_imm   = 1'b1;
                dec_write = 1'b1;
                dec_rt    = 1'b1;
            end
            OpBeq: begin
                dec_op     = AluSub;
                dec_branch = 1'b1;
            end
            OpBne: begin
                dec_op     = AluSub;
                dec_branch = 1'b1;
                dec_ne     = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StFetch;
            alu_op    <= AluAdd;
            use_imm   <= 1'b0;
            reg_write <= 1'b0;
            write_rt  <= 1'b0;
            is_branch <= 1'b0;
            branch_ne <= 1'b0;
            retired   <= 1'b0;
            halted    <= 1'b0;
        end else if (stall || state == StHalt) begin
            retired <= 1'b0;
        end else begin
            retired <= 1'b0;
            case (state)
                StFetch: state <= StDecode;
                StDecode: begin
                    if (legal) begin
                        state     <= StExec;
                        alu_op    <= dec_op;
                        use_imm   <= dec_imm;
                        reg_write <= dec_write;
                        write_rt  <= dec_rt;
                        is_branch <= dec_branch;
                        branch_ne <= dec_ne;
                    end else begin
                        state  <= StHalt;
                        halted <= 1'b1;
                    end
                end
                StExec: state <= StWb;
                StWb: begin
                    state   <= StFetch;
                    retired <= 1'b1;
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: program memory, register file, ALU datapath.
// Optional memory-mapped port I/O on $26/$27 when MIPS_PORT_IO_EN is defined.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input logic        clk,
    input logic        reset,
    mips_core_if.slave io
);

    localparam int unsigned AddrW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    logic [31:0] imem [MEMORY_DEPTH];
    logic [31:0] regs [32];

    logic [31:0] pc, ir, a, b, imm, alu_out, port_out;
    logic [31:0] word_off, rs_val, rt_val, imm_ext, src_b, pc_plus4;
    logic [AddrW-1:0] fetch_idx, prog_idx;
    logic [4:0]  rs, rt, rd, dest;
    logic        branch_taken;

    state_e  state;
    alu_op_e alu_op;
    logic    use_imm, reg_write, write_rt, is_branch, branch_ne, retired, halted;

    mips_mc_control u_control (
        .clk       (clk),
        .reset     (reset),
        .stall     (io.Stall),
        .opcode    (ir[31:26]),
        .funct     (ir[5:0]),
        .state     (state),
        .alu_op    (alu_op),
        .use_imm   (use_imm),
        .reg_write (reg_write),
        .write_rt  (write_rt),
        .is_branch (is_branch),
        .branch_ne (branch_ne),
        .retired   (retired),
        .halted    (halted)
    );

    assign rs = ir[25:21];
    assign rt = ir[20:16];
    assign rd = ir[15:11];

    // PCs outside the memory window wrap instead of faulting.
    assign word_off  = pc - RESET_PC;
    assign fetch_idx = AddrW'((word_off >> 2) % MEMORY_DEPTH);
    assign prog_idx  = AddrW'(io.prog_addr % MEMORY_DEPTH);

    assign imm_ext  = (ir[31:26] == OpOri) ? {16'b0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
    assign src_b    = use_imm ? imm : b;
    assign dest     = write_rt ? rt : rd;
    assign pc_plus4 = pc + 32'd4;
    // ALUOut holds A-B for branches, so equality is a zero test.
    assign branch_taken = is_branch & ((alu_out == 32'd0) ^ branch_ne);

    always_comb begin
        rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
        rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
`ifdef MIPS_PORT_IO_EN
        if (rs == 5'd26) rs_val = {24'b0, io.PortIn};
        if (rt == 5'd26) rt_val = {24'b0, io.PortIn};
`endif
    end

    always_ff @(posedge clk) begin
        if (io.prog_we) imem[prog_idx] <= io.prog_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            port_out <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (!io.Stall) begin
            case (state)
                StFetch: ir <= imem[fetch_idx];
                StDecode: begin
                    a   <= rs_val;
                    b   <= rt_val;
                    imm <= imm_ext;
                end
                StExec: alu_out <= alu_compute(a, src_b, alu_op);
                StWb: begin
                    pc <= branch_taken ? pc_plus4 + (imm << 2) : pc_plus4;
                    if (reg_write && dest != 5'd0) regs[dest] <= alu_out;
`ifdef MIPS_PORT_IO_EN
                    if (reg_write && dest == 5'd27) port_out <= alu_out;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef MIPS_PORT_IO_EN
    logic unused_port_in;
    assign unused_port_in = ^io.PortIn;
`endif
    logic unused_shamt;
    assign unused_shamt = ^ir[10:6];

    assign io.ALUResultOut = alu_out;
    assign io.PortOut      = port_out;
    assign io.PCOut        = pc;
    assign io.InstrRetired = retired;
    assign io.Halted       = halted;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed self-checking bench for mips_multicycle_core: reset, arithmetic,
// branches, stall/halt, register 0 and port I/O scenarios.
module tb_mips_multicycle_core;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_core_if io ();

    mips_multicycle_core #(
        .MEMORY_DEPTH (32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] word);
        io.prog_we   = 1'b1;
        io.prog_addr = 32'(idx);
        io.prog_data = word;
        tick();
        io.prog_we   = 1'b0;
    endtask

    task automatic wait_retire(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!io.InstrRetired && n < 8);
        check(tag, 32'(io.InstrRetired), 32'd1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        io.Stall     = 1'b0;
        io.PortIn    = 8'hA5;
        io.prog_we   = 1'b0;
        io.prog_addr = '0;
        io.prog_data = '0;

        // Arithmetic program, loaded while reset is held low.
        load(0, itype(6'h08, 5'd0, 5'd8, 16'd5));
        load(1, itype(6'h08, 5'd0, 5'd9, 16'hFFFD));
        load(2, rtype(5'd8, 5'd9, 5'd10, 6'h20));
        load(3, rtype(5'd8, 5'd0, 5'd11, 6'h27));
        load(4, 32'hFC00_0000);
        tick();
        tick();
        check("rst.pc", io.PCOut, 32'h0);
        check("rst.halted", 32'(io.Halted), 32'd0);
        check("rst.alu", io.ALUResultOut, 32'h0);
        check("rst.retired", 32'(io.InstrRetired), 32'd0);
        check("rst.portout", io.PortOut, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("first.noretire", 32'(io.InstrRetired), 32'd0);
        end
        tick();
        check("first.retire", 32'(io.InstrRetired), 32'd1);
        check("addi.pos", io.ALUResultOut, 32'h0000_0005);
        check("addi.pc", io.PCOut, 32'h4);
        tick();
        check("retire.onecycle", 32'(io.InstrRetired), 32'd0);
        wait_retire("addi.neg.ret");
        check("addi.neg", io.ALUResultOut, 32'hFFFF_FFFD);
        wait_retire("add.ret");
        check("add.wrap", io.ALUResultOut, 32'h0000_0002);
        wait_retire("nor.ret");
        check("nor", io.ALUResultOut, 32'hFFFF_FFFA);
        check("nor.pc", io.PCOut, 32'h10);

        // beq taken forward, then bne taken backward.
        reset = 1'b0;
        load(0, itype(6'h08, 5'd0, 5'd8, 16'd7));
        load(1, itype(6'h08, 5'd0, 5'd9, 16'd7));
        load(2, itype(6'h04, 5'd8, 5'd9, 16'd2));
        load(3, 32'hFC00_0000);
        load(5, itype(6'h05, 5'd8, 5'd0, 16'hFFFA));
        tick();
        reset = 1'b1;
        wait_retire("beq.r0");
        wait_retire("beq.r1");
        wait_retire("beq.ret");
        check("beq.pc", io.PCOut, 32'h14);
        check("beq.alu", io.ALUResultOut, 32'h0);
        wait_retire("bne.back.ret");
        check("bne.back.pc", io.PCOut, 32'h0);

        // bne not taken.
        reset = 1'b0;
        load(2, itype(6'h05, 5'd8, 5'd9, 16'd2));
        tick();
        reset = 1'b1;
        wait_retire("bne.r0");
        wait_retire("bne.r1");
        wait_retire("bne.ret");
        check("bne.pc", io.PCOut, 32'hC);

        // Stall in EXEC, then an illegal opcode halts.
        reset = 1'b0;
        load(0, itype(6'h0D, 5'd0, 5'd8, 16'h8001));
        load(1, 32'hFC00_0000);
        tick();
        reset = 1'b1;
        tick();
        tick();
        io.Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.noretire", 32'(io.InstrRetired), 32'd0);
        end
        check("stall.alu", io.ALUResultOut, 32'h0);
        check("stall.pc", io.PCOut, 32'h0);
        io.Stall = 1'b0;
        tick();
        check("resume.alu", io.ALUResultOut, 32'h0000_8001);
        check("resume.noretire", 32'(io.InstrRetired), 32'd0);
        tick();
        check("resume.retire", 32'(io.InstrRetired), 32'd1);
        check("resume.pc", io.PCOut, 32'h4);
        tick();
        tick();
        check("halt.set", 32'(io.Halted), 32'd1);
        check("halt.pc", io.PCOut, 32'h4);
        io.Stall = 1'b1;
        tick();
        tick();
        io.Stall = 1'b0;
        tick();
        tick();
        tick();
        check("halt.sticky", 32'(io.Halted), 32'd1);
        check("halt.pcfrozen", io.PCOut, 32'h4);
        check("halt.noretire", 32'(io.InstrRetired), 32'd0);
        io.Stall = 1'b1;
        reset    = 1'b0;
        tick();
        check("rststall.halted", 32'(io.Halted), 32'd0);
        check("rststall.pc", io.PCOut, 32'h0);
        check("rststall.alu", io.ALUResultOut, 32'h0);
        io.Stall = 1'b0;

        // Register 0 discard and port I/O.
        load(0, itype(6'h08, 5'd0, 5'd8, 16'd4));
        load(1, rtype(5'd8, 5'd8, 5'd0, 6'h20));
        load(2, rtype(5'd0, 5'd8, 5'd13, 6'h20));
        load(3, rtype(5'd26, 5'd0, 5'd27, 6'h25));
        load(4, 32'hFC00_0000);
        tick();
        reset = 1'b1;
        wait_retire("r0.setup");
        wait_retire("r0.write.ret");
        check("r0.write.alu", io.ALUResultOut, 32'h8);
        wait_retire("r0.read.ret");
        check("r0.read", io.ALUResultOut, 32'h4);
        wait_retire("port.ret");
`ifdef MIPS_PORT_IO_EN
        check("port.alu", io.ALUResultOut, 32'h0000_00A5);
        check("port.out", io.PortOut, 32'h0000_00A5);
`else
        check("port.alu", io.ALUResultOut, 32'h0);
        check("port.out", io.PortOut, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
